// File: rtl/spi_arb_pkg.sv
// Shared types and widths for the SPI register-port arbiter.
package spi_arb_pkg;

    localparam int AW = 5;
    localparam int DW = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner select: scans from ptr+1 upward (wrapping), first request wins.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_win
);

    int            w_idx;
    logic          w_found;
    logic [PW-1:0] w_sel;

    always_comb begin
        o_win   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        w_sel   = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= N) w_idx = w_idx - N;
            w_sel = PW'(w_idx);
            if (!w_found && i_req[w_sel]) begin
                o_win[w_sel] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_arb.sv
// Lock-based arbiter sharing one SPI register port among n_req requesters,
// with zero-latency forwarding, registered read return and hold watchdog.
module spi_arb
    import spi_arb_pkg::*;
#(
    parameter int n_req    = 2,
    parameter int hold_max = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [n_req-1:0]    req_lock,
    output logic [n_req-1:0]    req_gnt,
    input  logic [n_req*AW-1:0] req_addr,
    input  logic [n_req-1:0]    req_we,
    input  logic [n_req-1:0]    req_re,
    input  logic [n_req*DW-1:0] req_wd,
    output logic [DW-1:0]       req_rd,
    output logic [n_req-1:0]    req_rvalid,
    output logic [AW-1:0]       spi_addr,
    output logic                spi_we,
    output logic                spi_re,
    output logic [DW-1:0]       spi_wd,
    input  logic [DW-1:0]       spi_rd,
    output logic [n_req-1:0]    err_to,
    input  logic                err_clr
);

    localparam int OW = (n_req > 1) ? $clog2(n_req) : 1;
    localparam int CW = (hold_max > 0) ? $clog2(hold_max + 1) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'((hold_max > 0) ? hold_max - 1 : 0);

    state_t           r_state;
    logic [n_req-1:0] r_gnt;
    logic [n_req-1:0] r_rvalid;
    logic [n_req-1:0] r_err;
    logic [n_req-1:0] r_need_drop;
    logic [OW-1:0]    r_ptr;
    logic [OW-1:0]    r_own;
    logic [CW-1:0]    r_cnt;
    logic [DW-1:0]    r_rd;

    logic [n_req-1:0] w_elig;
    logic [n_req-1:0] w_win;
    logic [OW-1:0]    w_win_idx;
    logic             w_expire;

    // A requester cut off by the watchdog must drop its lock once before it counts again.
    assign w_elig   = req_lock & ~r_need_drop;
    assign w_expire = (hold_max > 0) && (r_cnt == HOLD_LAST);

    rr_pick #(
        .N  (n_req),
        .PW (OW)
    ) u_pick (
        .i_req (w_elig),
        .i_ptr (r_ptr),
        .o_win (w_win)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < n_req; i++)
            if (w_win[i]) w_win_idx = OW'(i);
    end

    always_comb begin
        spi_addr = '0;
        spi_we   = 1'b0;
        spi_re   = 1'b0;
        spi_wd   = '0;
        if (r_state == ST_OWN) begin
            spi_addr = req_addr[int'(r_own)*AW +: AW];
            spi_we   = req_we[r_own];
            spi_re   = req_re[r_own];
            spi_wd   = req_wd[int'(r_own)*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_ptr       <= OW'(n_req - 1);
            r_own       <= '0;
            r_cnt       <= '0;
            r_rd        <= '0;
            r_rvalid    <= '0;
            r_err       <= '0;
            r_need_drop <= '0;
        end else begin
            r_rvalid <= '0;
            if (spi_re) begin
                r_rd            <= spi_rd;
                r_rvalid[r_own] <= 1'b1;
            end
            if (err_clr) r_err <= '0;
            r_need_drop <= r_need_drop & req_lock;

            case (r_state)
                ST_IDLE: begin
                    if (|w_elig) begin
                        r_gnt   <= w_win;
                        r_own   <= w_win_idx;
                        r_cnt   <= '0;
                        r_state <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
                    if (!req_lock[r_own] || w_expire) begin
                        r_gnt   <= '0;
                        r_ptr   <= r_own;
                        r_state <= ST_IDLE;
                        // Forced release: flag set here overrides a same-cycle clear.
                        if (req_lock[r_own]) begin
                            r_err[r_own]       <= 1'b1;
                            r_need_drop[r_own] <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_gnt    = r_gnt;
    assign req_rd     = r_rd;
    assign req_rvalid = r_rvalid;
    assign err_to     = r_err;

endmodule
